data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Memory-side responder for the CPU's load/store interface.
- The CPU presents the address and drives READ or WRITE. This block asserts BUSYWAIT to stall the CPU, completes the access after a fixed latency, and returns read data.
- It sits between the CPU datapath and the memory array, and is the counterpart to the CPU's load/store path.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data width in bits.
- DEPTH, 256 (2**ADDR_W), number of storage words.
- LATENCY, 5, clock edges spent in BUSY before the access commits; legal range 1..15.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- READ  in  1  load request from the CPU.
- WRITE  in  1  store request from the CPU.
- ADDRESS  in  ADDR_W  word address, valid while READ or WRITE is high.
- WRITEDATA  in  DATA_W  store data, valid while WRITE is high.
- READDATA  out  DATA_W  load result.
- BUSYWAIT  out  1  stall request to the CPU.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state=IDLE, counter=0, READDATA=0, all DEPTH words cleared to 0.
  - Any in-flight access is aborted: no write commits.
  - BUSYWAIT=0 while in reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - BUSYWAIT = READ ^ WRITE, combinational, so the CPU stalls in the request cycle itself.
  - At the rising edge with exactly one of READ/WRITE high: latch ADDRESS, WRITEDATA and op; load counter=LATENCY-1; go to BUSY.
  - READ and WRITE both high is illegal: ignored, BUSYWAIT=0, stay in IDLE, memory untouched.
- BUSY:
  - BUSYWAIT=1.
  - Each edge with counter!=0: decrement counter.
  - Edge with counter==0: commit the access and go to DONE.
    - Read: READDATA <= mem[latched address].
    - Write: mem[latched address] <= latched data; READDATA unchanged.
  - Input changes during BUSY are ignored; only latched values are used.
- DONE:
  - BUSYWAIT=0 for exactly one cycle.
  - Returns to IDLE at the next edge unconditionally, ignoring READ/WRITE. The CPU drops its request at that same edge, so there is no re-trigger.
- Timing for a request sampled at edge E0:
  - BUSYWAIT is high from the request cycle through edge E0+LATENCY.
  - The access commits at E0+LATENCY.
  - BUSYWAIT is low in the cycle after E0+LATENCY.
  - Total stall = LATENCY+1 cycles including the request cycle.
- Back-to-back requests: the earliest new request is sampled at the edge that leaves DONE's successor IDLE cycle (one idle cycle minimum between accesses).
- READDATA holds its value until the next read commits or reset.
- Address wrap: address bits beyond log2(DEPTH) are ignored (index = ADDRESS mod DEPTH).
- Reset asserted mid-BUSY: immediate return to IDLE, pending write discarded, memory cleared.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - ADDR_W/DATA_W defaults;
  - op encoding OP_READ=1'b0, OP_WRITE=1'b1.
- One natural sub-module, mem_array: DEPTH x DATA_W storage with synchronous write, combinational read and asynchronous clear.
- The FSM, counter and request latches stay in data_memory_responder.

Test Plan:
- Reset, then READ at address 0x10 -> BUSYWAIT high for 6 cycles (LATENCY=5), READDATA=0x00, BUSYWAIT low in DONE.
- WRITE 0xA5 to 0x3C, then READ 0x3C -> WRITE stall 6 cycles; READ returns READDATA=0xA5 at commit edge E0+5.
- WRITE 0x11 to 0x20, changing ADDRESS to 0x21 and WRITEDATA to 0xFF during BUSY -> mem[0x20]=0x11, mem[0x21] still 0x00.
- READ and WRITE both high for 3 cycles -> BUSYWAIT stays 0, state IDLE, subsequent READ of ADDRESS shows no change.
- WRITE 0x77 to 0x05; pulse RESET_N low at BUSY cycle 2 -> state IDLE, BUSYWAIT=0, READ 0x05 returns 0x00.
- LATENCY=1 build: READ 0xFF after writing 0x5A -> BUSYWAIT high exactly 2 cycles, READDATA=0x5A, one DONE cycle before IDLE.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types and default widths for the data memory responder.
package data_memory_responder_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/data_memory_responder_mem_array.sv
// DEPTH x DATA_W storage: synchronous write, combinational read, async clear.
module data_memory_responder_mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage: reset clears every word, otherwise write on enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_memory_responder.sv
// CPU load/store responder: stalls the CPU, commits after LATENCY edges in BUSY.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = 2 ** ADDR_W,
  parameter int unsigned LATENCY = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  op_t               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_readdata;
  logic              w_req;
  logic              w_busywait;
  logic              w_commit;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_mem_rdata;

  // Exactly one of READ/WRITE is a legal request; both high is ignored.
  assign w_req = READ ^ WRITE;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, stall and commit decode; IDLE stall is combinational so the
  // CPU freezes in its request cycle. Reset forces the stall low.
  always_comb begin
    w_next_state = r_state;
    w_busywait   = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busywait = RESET_N & w_req;
        if (w_req) begin
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        w_busywait = 1'b1;
        if (r_cnt == '0) begin
          w_commit     = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request latches and latency counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt  <= '0;
      r_op   <= OP_READ;
      r_addr <= '0;
      r_data <= '0;
    end else if (r_state == IDLE && w_req) begin
      r_cnt  <= CNT_W'(LATENCY - 1);
      r_op   <= WRITE ? OP_WRITE : OP_READ;
      r_addr <= ADDRESS;
      r_data <= WRITEDATA;
    end else if (r_state == BUSY && r_cnt != '0) begin
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  // Read data holds until the next read commits.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_readdata <= '0;
    end else if (w_commit && r_op == OP_READ) begin
      r_readdata <= w_mem_rdata;
    end
  end

  assign w_idx    = r_addr[IDX_W-1:0];
  assign w_mem_we = w_commit && (r_op == OP_WRITE);

  data_memory_responder_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_we    (w_mem_we),
    .i_addr  (w_idx),
    .i_wdata (r_data),
    .o_rdata (w_mem_rdata)
  );

  assign READDATA = r_readdata;
  assign BUSYWAIT = w_busywait;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (LATENCY=5 and LATENCY=1 builds).
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd5, wr5, rd1, wr1;
  logic [7:0] addr5, wd5, rdata5, addr1, wd1, rdata1;
  logic       bw5, bw1;

  int checks = 0;
  int errors = 0;
  int stall;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(5)) u_dut5 (
    .CLK(clk), .RESET_N(rst_n), .READ(rd5), .WRITE(wr5), .ADDRESS(addr5),
    .WRITEDATA(wd5), .READDATA(rdata5), .BUSYWAIT(bw5)
  );

  data_memory_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(1)) u_dut1 (
    .CLK(clk), .RESET_N(rst_n), .READ(rd1), .WRITE(wr1), .ADDRESS(addr1),
    .WRITEDATA(wd1), .READDATA(rdata1), .BUSYWAIT(bw1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (sel) begin
      rd1 = r; wr1 = w; addr1 = a; wd1 = d;
    end else begin
      rd5 = r; wr5 = w; addr5 = a; wd5 = d;
    end
  endtask

  function automatic logic busy(input bit sel);
    return sel ? bw1 : bw5;
  endfunction

  function automatic logic [31:0] st(input bit sel);
    return sel ? 32'(u_dut1.r_state) : 32'(u_dut5.r_state);
  endfunction

  // Entered 1 time unit after a rising edge; returns in the DONE cycle with
  // the request dropped. Counts cycles where the stall was observed high.
  task automatic access(input bit sel, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input bit alt_en,
                        input logic [7:0] alt_a, input logic [7:0] alt_d,
                        output int n);
    n = 0;
    drive(sel, !wr, wr, a, d);
    #1;
    while (busy(sel) === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #2;
      if (alt_en && n == 1) drive(sel, !wr, wr, alt_a, alt_d);
    end
    drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Step from DONE into the idle gap cycle.
  task automatic gap(input bit sel, input string tag);
    @(posedge clk); #1;
    chk(tag, st(sel), 32'(IDLE));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    chk("rst_busywait_gated", 32'(bw5), 32'h0);
    chk("rst_readdata", 32'(rdata5), 32'h00);
    chk("rst_state", st(1'b0), 32'(IDLE));
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Read of untouched location after reset.
    access(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, stall);
    chk("rd10_stall", 32'(stall), 32'd6);
    chk("rd10_data", 32'(rdata5), 32'h00);
    chk("rd10_done_state", st(1'b0), 32'(DONE));
    gap(1'b0, "rd10_idle");

    // Write then read back.
    access(1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, 8'h00, stall);
    chk("wr3c_stall", 32'(stall), 32'd6);
    chk("wr3c_rdata_hold", 32'(rdata5), 32'h00);
    gap(1'b0, "wr3c_idle");
    access(1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, stall);
    chk("rd3c_stall", 32'(stall), 32'd6);
    chk("rd3c_data", 32'(rdata5), 32'hA5);
    gap(1'b0, "rd3c_idle");

    // Inputs changed during BUSY must be ignored.
    access(1'b0, 1'b1, 8'h20, 8'h11, 1'b1, 8'h21, 8'hFF, stall);
    chk("wr20_stall", 32'(stall), 32'd6);
    gap(1'b0, "wr20_idle");
    access(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, stall);
    chk("rd20_data", 32'(rdata5), 32'h11);
    gap(1'b0, "rd20_idle");
    access(1'b0, 1'b0, 8'h21, 8'h00, 1'b0, 8'h00, 8'h00, stall);
    chk("rd21_data", 32'(rdata5), 32'h00);
    gap(1'b0, "rd21_idle");

    // READ and WRITE together: ignored for three cycles.
    drive(1'b0, 1'b1, 1'b1, 8'h3C, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("both_busywait", 32'(bw5), 32'h0);
      @(posedge clk); #1;
      chk("both_state", st(1'b0), 32'(IDLE));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    access(1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, stall);
    chk("both_rd3c_stall", 32'(stall), 32'd6);
    chk("both_rd3c_data", 32'(rdata5), 32'hA5);
    gap(1'b0, "both_idle");

    // Reset in BUSY cycle 2 discards the write and clears memory.
    drive(1'b0, 1'b0, 1'b1, 8'h05, 8'h77);
    @(posedge clk); #2;
    chk("rstmid_busy1", 32'(bw5), 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busywait", 32'(bw5), 32'h0);
    chk("rstmid_state", st(1'b0), 32'(IDLE));
    chk("rstmid_readdata", 32'(rdata5), 32'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 8'h00, stall);
    chk("rstmid_rd05_stall", 32'(stall), 32'd6);
    chk("rstmid_rd05_data", 32'(rdata5), 32'h00);
    gap(1'b0, "rstmid_idle05");
    access(1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, stall);
    chk("rstmid_rd3c_cleared", 32'(rdata5), 32'h00);
    gap(1'b0, "rstmid_idle3c");

    // LATENCY=1 build.
    access(1'b1, 1'b1, 8'hFF, 8'h5A, 1'b0, 8'h00, 8'h00, stall);
    chk("l1_wrff_stall", 32'(stall), 32'd2);
    chk("l1_wrff_done", st(1'b1), 32'(DONE));
    gap(1'b1, "l1_wrff_idle");
    access(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, stall);
    chk("l1_rdff_stall", 32'(stall), 32'd2);
    chk("l1_rdff_data", 32'(rdata1), 32'h5A);
    chk("l1_rdff_done", st(1'b1), 32'(DONE));
    gap(1'b1, "l1_rdff_idle");
    chk("l1_idle_busywait", 32'(bw1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
